// File: rtl/ram_rd_pkg.sv
// Shared widths and types for the RAM burst read path.
// Return words carry their own end-of-burst flag through the return FIFO.
package ram_rd_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } ret_word_t;

endpackage

// File: rtl/ram_ret_fifo.sv
// First-word-fall-through FIFO for returned RAM words; head visible the cycle after push.
// Pop is ignored when empty; push while full is dropped unless a pop frees the slot in the same cycle.
module ram_ret_fifo
    import ram_rd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  ret_word_t        push_dat_i,
    input  logic             pop_i,
    output ret_word_t        head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    ret_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Credit-gated burst read initiator: issues one read per clock, first read 1 cycle after accept.
// Stalls issue when no return-FIFO slot is free; out stream holds its head under backpressure.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CREDIT_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_read,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err_overflow
);

    rd_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]     issue_rem_q, issue_rem_d;
    logic [LEN_W-1:0]     ret_rem_q, ret_rem_d;
    logic [CREDIT_W-1:0]  credits_q, credits_d;
    logic [CREDIT_W-1:0]  outstanding_q, outstanding_d;
    logic                 rd_read_q;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 err_q;

    logic                 issue;
    logic                 pop;
    logic                 ret_accept;
    logic                 overflow;
    logic                 head_vld;
    ret_word_t            push_word;
    ret_word_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CREDIT_W-1:0]  fifo_count;

    ram_ret_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CREDIT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (aresetn),
        .push_i     (ret_accept),
        .push_dat_i (push_word),
        .pop_i      (pop),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // Returns arriving with nothing outstanding predate a reset and are dropped.
    assign ret_accept = rd_valid && (outstanding_q != '0);
    assign push_word  = '{last: (ret_rem_q == '0), data: rd_data};
    assign overflow   = ret_accept && fifo_full && !pop;

    assign head_vld  = (fifo_count != '0);
    assign out_valid = !fifo_empty;
    assign out_data  = head_vld ? head.data : '0;
    assign out_last  = head_vld && head.last;
    assign pop       = out_valid && out_ready;

    assign rd_read      = rd_read_q;
    assign rd_addr      = rd_addr_q;
    assign err_overflow = err_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (issue && (issue_rem_q == '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && head.last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        issue     = (state_q == ST_ISSUE) && (credits_q != '0);
    end

    always_comb begin
        cur_addr_d  = cur_addr_q;
        issue_rem_d = issue_rem_q;
        ret_rem_d   = ret_rem_q;
        rd_addr_d   = rd_addr_q;
        if ((state_q == ST_IDLE) && cmd_valid) begin
            cur_addr_d  = cmd_addr;
            issue_rem_d = cmd_len;
            ret_rem_d   = cmd_len;
        end
        if (issue) begin
            rd_addr_d  = cur_addr_q;
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            if (issue_rem_q != '0) begin
                issue_rem_d = issue_rem_q - LEN_W'(1);
            end
        end
        if (ret_accept && (ret_rem_q != '0)) begin
            ret_rem_d = ret_rem_q - LEN_W'(1);
        end
    end

    always_comb begin
        case ({issue, pop})
            2'b10:   credits_d = credits_q - CREDIT_W'(1);
            2'b01:   credits_d = credits_q + CREDIT_W'(1);
            default: credits_d = credits_q;
        endcase
        case ({issue, ret_accept})
            2'b10:   outstanding_d = outstanding_q + CREDIT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CREDIT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cur_addr_q    <= '0;
            issue_rem_q   <= '0;
            ret_rem_q     <= '0;
            credits_q     <= CREDIT_W'(FIFO_DEPTH);
            outstanding_q <= '0;
            rd_read_q     <= 1'b0;
            rd_addr_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            cur_addr_q    <= cur_addr_d;
            issue_rem_q   <= issue_rem_d;
            ret_rem_q     <= ret_rem_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            rd_read_q     <= issue;
            rd_addr_q     <= rd_addr_d;
            err_q         <= err_q | overflow;
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader against a 2-cycle-latency 256x16 RAM model holding mem[i]=i*3.
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [7:0]  rd_addr;
    logic        rd_read;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        err_overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit inv_on = 1'b0;

    logic [7:0]  rd_q [$];
    int          rd_cyc [$];
    logic [16:0] pop_q [$];
    int          pop_cyc [$];

    ram_burst_reader #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .rd_addr      (rd_addr),
        .rd_read      (rd_read),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // RAM model: not reset, so reads in flight across a DUT reset still return.
    logic [15:0] mem [256];
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [15:0] d2 = '0;
    always @(posedge clk) begin
        v1 <= rd_read;
        a1 <= rd_addr;
        v2 <= v1;
        d2 <= mem[a1];
    end
    assign rd_valid = v2;
    assign rd_data  = d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (aresetn) begin
            if (rd_read) begin
                rd_q.push_back(rd_addr);
                rd_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                pop_q.push_back({out_last, out_data});
                pop_cyc.push_back(cyc);
            end
            if (inv_on) begin
                check("credit_inv", 32'(dut.credits_q) + 32'(dut.outstanding_q) + 32'(dut.fifo_count), 32'd8);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_q.delete();
        rd_cyc.delete();
        pop_q.delete();
        pop_cyc.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_pops"}, 32'(pop_q.size() >= n), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);

        // Reset values
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rd_read", 32'(rd_read), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // 1: single word
        clr();
        out_ready = 1'b1;
        send_cmd(8'h05, 8'd0);
        wait_pops(1, 50, "t1");
        check("t1_busy_before_pop", 32'(busy), 32'd1);
        tick();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) tick();
        check("t1_nreads", 32'(rd_q.size()), 32'd1);
        check("t1_addr", 32'(rd_q[0]), 32'h05);
        check("t1_issue_lat", 32'(rd_cyc[0]), 32'(acc_cyc + 1));
        check("t1_out_lat", 32'(pop_cyc[0]), 32'(acc_cyc + 4));
        check("t1_word", 32'(pop_q[0]), {15'd0, 1'b1, 16'd15});

        // 2: 8-word burst, full rate
        clr();
        send_cmd(8'h10, 8'd7);
        wait_pops(8, 80, "t2");
        repeat (4) tick();
        check("t2_nreads", 32'(rd_q.size()), 32'd8);
        check("t2_npops", 32'(pop_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_addr%0d", i), 32'(rd_q[i]), 32'(8'h10 + i));
            check($sformatf("t2_rdcyc%0d", i), 32'(rd_cyc[i]), 32'(acc_cyc + 1 + i));
            check($sformatf("t2_word%0d", i), 32'(pop_q[i]), 32'({(i == 7), 16'(48 + 3 * i)}));
        end

        // 3: backpressure
        clr();
        out_ready = 1'b0;
        send_cmd(8'h00, 8'd31);
        repeat (40) tick();
        check("t3_stall_reads", 32'(rd_q.size()), 32'd8);
        check("t3_stall_rd_read", 32'(rd_read), 32'd0);
        check("t3_stall_err", 32'(err_overflow), 32'd0);
        check("t3_stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_pops(32, 300, "t3");
        repeat (4) tick();
        check("t3_nreads", 32'(rd_q.size()), 32'd32);
        check("t3_npops", 32'(pop_q.size()), 32'd32);
        check("t3_err", 32'(err_overflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t3_word%0d", i), 32'(pop_q[i]), 32'({(i == 31), 16'(3 * i)}));
        end
        // A pop presented on one sample commits at the next edge; the freed credit issues on the edge after.
        for (int k = 0; k < 24; k++) begin
            check($sformatf("t3_resume%0d", k), 32'(rd_cyc[8 + k]), 32'(pop_cyc[k] + 2));
        end

        // 4: address wrap
        clr();
        send_cmd(8'hFE, 8'd3);
        wait_pops(4, 60, "t4");
        repeat (4) tick();
        check("t4_addr0", 32'(rd_q[0]), 32'hFE);
        check("t4_addr1", 32'(rd_q[1]), 32'hFF);
        check("t4_addr2", 32'(rd_q[2]), 32'h00);
        check("t4_addr3", 32'(rd_q[3]), 32'h01);
        check("t4_word0", 32'(pop_q[0]), 32'h002FA);
        check("t4_word1", 32'(pop_q[1]), 32'h002FD);
        check("t4_word2", 32'(pop_q[2]), 32'h00000);
        check("t4_word3", 32'(pop_q[3]), 32'h10003);

        // 5: 256-word burst with random backpressure
        clr();
        inv_on = 1'b1;
        send_cmd(8'h00, 8'd255);
        for (int k = 0; k < 4000 && pop_q.size() < 256; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        inv_on = 1'b0;
        check("t5_npops", 32'(pop_q.size()), 32'd256);
        check("t5_err", 32'(err_overflow), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 256 && i < pop_q.size(); i++) begin
            check($sformatf("t5_word%0d", i), 32'(pop_q[i]), 32'({(i == 255), 16'(3 * i)}));
        end

        // 6: reset mid-burst
        clr();
        send_cmd(8'h80, 8'd15);
        repeat (4) tick();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_rd_read", 32'(rd_read), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        aresetn = 1'b1;
        repeat (5) tick();
        check("t6_stray_valid", 32'(out_valid), 32'd0);
        check("t6_stray_err", 32'(err_overflow), 32'd0);
        check("t6_stray_pops", 32'(pop_q.size()), 32'd0);
        clr();
        send_cmd(8'h40, 8'd1);
        wait_pops(2, 60, "t6");
        repeat (6) tick();
        check("t6_npops", 32'(pop_q.size()), 32'd2);
        check("t6_word0", 32'(pop_q[0]), 32'h000C0);
        check("t6_word1", 32'(pop_q[1]), 32'h100C3);
        check("t6_err", 32'(err_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side initiator for the 256x16 fixed-latency RAM.
- Accepts a burst command (start address, length) and issues one read per cycle on the RAM read port.
- Collects the returned words into a small return FIFO and presents them as a valid/ready stream with a last flag.
- The RAM read pipeline cannot stall, so issue is gated by credits: one credit per free FIFO slot, counting reads still in flight.

Parameters:
FIFO_DEPTH, 8, return FIFO entries and initial credit count (power of 2, 2..64)
CREDIT_W, $clog2(FIFO_DEPTH)+1, width of the credit and outstanding counters

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset (0 = reset)
cmd_valid  in  1  burst command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  8  first RAM address
cmd_len  in  8  burst length minus 1 (0 = 1 word, 255 = 256 words)
rd_addr  out  8  RAM read address
rd_read  out  1  RAM read strobe
rd_data  in  16  RAM read data
rd_valid  in  1  RAM read data valid (fixed latency after rd_read)
out_data  out  16  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  final word of the burst
busy  out  1  state != IDLE
err_overflow  out  1  sticky: rd_valid arrived while FIFO full

Behaviour:
Reset values (aresetn=0, async):
- State IDLE; cmd_ready=1.
- rd_read=0, rd_addr=0.
- out_valid=0, out_last=0, out_data=0.
- credits=FIFO_DEPTH, outstanding=0, FIFO empty.
- busy=0, err_overflow=0.

FSM:
- IDLE: cmd_ready=1. On cmd_valid, latch cur_addr=cmd_addr, issue_rem=cmd_len, ret_rem=cmd_len, then go to ISSUE.
- ISSUE: in any cycle with credits>0, drive rd_read=1 and rd_addr=cur_addr (both registered outputs).
  - cur_addr increments mod 256, so 0xFF wraps to 0x00.
  - When issue_rem==0 on an issue cycle, go to DRAIN; otherwise issue_rem decrements.
  - With credits==0, rd_read=0 and rd_addr holds.
- DRAIN: no issue. Go to IDLE in the cycle the word with out_last=1 is popped (out_valid & out_ready & out_last).
- cmd_ready=0 outside IDLE. Only one burst is in flight at a time.

Credits:
- Each issue decrements credits; each FIFO pop increments them.
- Issue and pop in the same cycle leave credits unchanged.
- Invariant: credits + outstanding + fifo_count == FIFO_DEPTH.

Outstanding counter:
- +1 on issue, -1 on an accepted return.
- rd_valid with outstanding==0 is a stray return (from reads issued before a reset). It is dropped silently and does not set err_overflow.

Return path:
- An accepted rd_valid pushes {rd_data, last} into the FIFO. last = (ret_rem==0); otherwise ret_rem decrements.
- The data order is the issue order.
- Push into a full FIFO cannot happen by construction. If it does, the word is dropped and err_overflow sets (sticky until reset).

FIFO and output stream:
- The FIFO is first-word-fall-through. out_valid = !empty; out_data and out_last come from the head entry.
- The head is held stable while out_valid & !out_ready.
- Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot first) and when it is empty (the word appears the next cycle).

Latency and throughput:
- Command accept to first rd_read: 1 cycle.
- First valid output: RAM latency + 1 cycle.
- With out_ready held high and FIFO_DEPTH >= RAM latency + 2, issue runs at 1 word per clock.

Reset mid-burst:
- Everything returns to reset values immediately.
- Returns still in the RAM pipeline arrive with outstanding==0 and are discarded.

Decomposition:
- Package ram_rd_pkg:
  - ADDR_W=8, DATA_W=16, LEN_W=8.
  - typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} rd_state_t.
  - typedef struct packed {logic last; logic [DATA_W-1:0] data;} ret_word_t.
- Sub-module ram_ret_fifo: synchronous FWFT FIFO of ret_word_t with depth FIFO_DEPTH and async active-low reset. It exposes push, pop, full, empty and count.
- The top level holds the FSM, the credit/outstanding counters and the address generator.

Test Plan:
1. Preload mem[i]=i*3; cmd addr=5, len=0, out_ready=1. Required: a single rd_read with rd_addr=5; out_data=15 with out_last=1; busy falls after the pop; cmd_ready returns to 1.
2. cmd addr=0x10, len=7, out_ready=1. Required: rd_read high for 8 consecutive cycles on addresses 0x10..0x17; 8 beats of data 48..69 step 3; out_last only on the 8th beat.
3. Backpressure: cmd addr=0, len=31, out_ready=0.
   - Required: exactly 8 rd_read pulses, then rd_read=0; err_overflow stays 0.
   - Then raise out_ready. Required: all 32 words arrive in order, and rd_read resumes one cycle after each pop.
4. Wrap: cmd addr=0xFE, len=3. Required: rd_addr sequence FE, FF, 00, 01; data 0x2FA, 0x2FD, 0, 3.
5. Toggle out_ready randomly at 50% across a 256-word burst. Required: no duplicated or lost words, the credit invariant holds every cycle, and err_overflow stays 0.
6. Pull aresetn low for 1 cycle mid-ISSUE of a 16-word burst, then release.
   - Required: out_valid=0 immediately and stray rd_valid pulses are ignored.
   - A new cmd addr=0x40, len=1 then returns exactly 0xC0 and 0xC3.
